// File: rtl/iso14443a_tx_pkg.sv
// ============================================================================
// Module   : iso14443a_tx_pkg
// Brief    : Shared types and constants for the ISO/IEC 14443-3A PICC tx framer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package iso14443a_tx_pkg;

    localparam int CRC_WIDTH     = 16;
    localparam int BITS_PER_BYTE = 8;

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_DATA       = 3'd1,
        S_PARITY     = 3'd2,
        S_CRC        = 3'd3,
        S_CRC_PARITY = 3'd4,
        S_END        = 3'd5
    } state_t;

endpackage

`default_nettype wire

// File: rtl/iso14443a_frame_encoder_odd_parity_acc.sv
// ============================================================================
// Module   : odd_parity_acc
// Brief    : Running odd-parity accumulator; clear seeds it to 1 so the value
//            is the bit that makes byte-plus-parity contain an odd count of ones.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module odd_parity_acc (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    input  logic bit_in,
    output logic parity
);

    logic acc;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            acc <= 1'b1;
        end else if (enable) begin
            acc <= acc ^ bit_in;
        end
    end

    assign parity = acc;

endmodule

`default_nettype wire

// File: rtl/iso14443a_frame_encoder.sv
// ============================================================================
// Module   : iso14443a_frame_encoder
// Brief    : ISO/IEC 14443-3A PICC tx framer: odd parity per byte, optional
//            CRC_A trailer. Optional SVA under FRAME_ENCODER_ASSERT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module iso14443a_frame_encoder
    import iso14443a_tx_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 fdt_trigger,
    input  logic                 append_crc,
    input  logic [CRC_WIDTH-1:0] crc,
    input  logic                 in_data,
    input  logic                 in_data_valid,
    input  logic                 in_last,
    output logic                 in_req,
    output logic                 out_data,
    output logic                 out_data_valid,
    output logic                 out_last,
    input  logic                 out_req
);

    state_t               state, state_nxt;
    logic [2:0]           bit_cnt, bit_cnt_nxt;
    logic                 crc_byte, crc_byte_nxt;
    logic                 crc_en, crc_en_nxt;
    logic [CRC_WIDTH-1:0] crc_hold, crc_hold_nxt;
    logic                 last_seen, last_seen_nxt;

    logic                 par_clear;
    logic                 par_en;
    logic                 par_bit;
    logic                 parity;
    logic                 crc_bit;

    localparam logic [2:0] LAST_BIT_IDX = 3'(BITS_PER_BYTE - 1);

    // crc_byte selects the half, bit_cnt the bit: LSB of each byte goes first
    assign crc_bit = crc_hold[{crc_byte, bit_cnt}];

    odd_parity_acc u_parity (
        .clk    (clk),
        .rst    (rst),
        .clear  (par_clear),
        .enable (par_en),
        .bit_in (par_bit),
        .parity (parity)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            bit_cnt   <= 3'd0;
            crc_byte  <= 1'b0;
            crc_en    <= 1'b0;
            crc_hold  <= '0;
            last_seen <= 1'b0;
        end else begin
            state     <= state_nxt;
            bit_cnt   <= bit_cnt_nxt;
            crc_byte  <= crc_byte_nxt;
            crc_en    <= crc_en_nxt;
            crc_hold  <= crc_hold_nxt;
            last_seen <= last_seen_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        bit_cnt_nxt    = bit_cnt;
        crc_byte_nxt   = crc_byte;
        crc_en_nxt     = crc_en;
        crc_hold_nxt   = crc_hold;
        last_seen_nxt  = last_seen;
        par_clear      = 1'b0;
        par_en         = 1'b0;
        par_bit        = 1'b0;
        out_data       = 1'b0;
        out_data_valid = 1'b0;
        out_last       = 1'b0;
        in_req         = 1'b0;

        case (state)
            S_IDLE: begin
                if (fdt_trigger && in_data_valid) begin
                    state_nxt     = S_DATA;
                    crc_en_nxt    = append_crc;
                    crc_hold_nxt  = crc;
                    bit_cnt_nxt   = 3'd0;
                    crc_byte_nxt  = 1'b0;
                    last_seen_nxt = 1'b0;
                    par_clear     = 1'b1;
                end
            end
            S_DATA: begin
                out_data_valid = 1'b1;
                out_data       = in_data;
                in_req         = out_req;
                if (out_req) begin
                    par_en        = 1'b1;
                    par_bit       = in_data;
                    bit_cnt_nxt   = bit_cnt + 3'd1;
                    last_seen_nxt = in_last;
                    if (bit_cnt == LAST_BIT_IDX || in_last) begin
                        state_nxt = S_PARITY;
                    end
                end
            end
            S_PARITY: begin
                out_data_valid = 1'b1;
                out_data       = parity;
                out_last       = last_seen && !crc_en;
                if (out_req) begin
                    bit_cnt_nxt = 3'd0;
                    par_clear   = 1'b1;
                    if (!last_seen) begin
                        state_nxt = S_DATA;
                    end else if (crc_en) begin
                        state_nxt    = S_CRC;
                        crc_byte_nxt = 1'b0;
                    end else begin
                        state_nxt = S_END;
                    end
                end
            end
            S_CRC: begin
                out_data_valid = 1'b1;
                out_data       = crc_bit;
                if (out_req) begin
                    par_en      = 1'b1;
                    par_bit     = crc_bit;
                    bit_cnt_nxt = bit_cnt + 3'd1;
                    if (bit_cnt == LAST_BIT_IDX) begin
                        state_nxt = S_CRC_PARITY;
                    end
                end
            end
            S_CRC_PARITY: begin
                out_data_valid = 1'b1;
                out_data       = parity;
                out_last       = crc_byte;
                if (out_req) begin
                    if (!crc_byte) begin
                        state_nxt    = S_CRC;
                        crc_byte_nxt = 1'b1;
                        bit_cnt_nxt  = 3'd0;
                        par_clear    = 1'b1;
                    end else begin
                        state_nxt = S_END;
                    end
                end
            end
            S_END: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

`ifdef FRAME_ENCODER_ASSERT_EN
    a_valid_after_trigger: assert property (@(posedge clk) disable iff (rst)
        (state == S_IDLE && fdt_trigger && in_data_valid) |=> out_data_valid);

    a_idle_after_rst: assert property (@(posedge clk)
        rst |=> state == S_IDLE);

    a_in_req_only_in_data: assert property (@(posedge clk)
        in_req |-> state == S_DATA);

    a_output_stable: assert property (@(posedge clk) disable iff (rst)
        (out_data_valid && !out_req) |=> ($stable(out_data) && $stable(out_last)));
`endif

endmodule

`default_nettype wire

// File: tb/tb_iso14443a_frame_encoder.sv
// ============================================================================
// Module   : tb_iso14443a_frame_encoder
// Brief    : Self-checking bench: queue-style frame model compared every cycle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_iso14443a_frame_encoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        fdt_trigger;
    logic        append_crc;
    logic [15:0] crc;
    logic        in_data;
    logic        in_data_valid;
    logic        in_last;
    logic        in_req;
    logic        out_data;
    logic        out_data_valid;
    logic        out_last;
    logic        out_req;

    iso14443a_frame_encoder dut (
        .clk            (clk),
        .rst            (rst),
        .fdt_trigger    (fdt_trigger),
        .append_crc     (append_crc),
        .crc            (crc),
        .in_data        (in_data),
        .in_data_valid  (in_data_valid),
        .in_last        (in_last),
        .in_req         (in_req),
        .out_data       (out_data),
        .out_data_valid (out_data_valid),
        .out_last       (out_last),
        .out_req        (out_req)
    );

    always #5 clk = ~clk;

    int   tests = 0;
    int   fails = 0;
    logic src     [0:127];
    logic exp_bit [0:255];
    int   exp_kind[0:255];   // 0 data, 1 parity, 2 crc, 3 crc parity
    int   exp_len;
    logic got     [0:255];

    task automatic chk1(input string name, input logic act, input logic req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, req, $time);
        end
    endtask

    task automatic chki(input string name, input int act, input int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    // CRC_A over src bytes (bits stored LSB first), preset 0x6363
    function automatic logic [15:0] crc_a(input int nbytes);
        logic [15:0] c;
        logic [7:0]  bt;
        logic [7:0]  ch;
        c = 16'h6363;
        for (int b = 0; b < nbytes; b++) begin
            for (int k = 0; k < 8; k++) bt[k] = src[b*8+k];
            ch = bt ^ c[7:0];
            ch = ch ^ {ch[3:0], 4'b0000};
            c  = {8'h00, c[15:8]} ^ {ch, 8'h00} ^ {5'b00000, ch, 3'b000} ^ {12'h000, ch[7:4]};
        end
        return c;
    endfunction

    task automatic push(input logic b, input int kind);
        exp_bit[exp_len]  = b;
        exp_kind[exp_len] = kind;
        exp_len++;
    endtask

    task automatic build_exp(input int n, input logic ac, input logic [15:0] cv);
        logic p;
        exp_len = 0;
        p = 1'b1;
        for (int i = 0; i < n; i++) begin
            push(src[i], 0);
            p = p ^ src[i];
            if ((i % 8) == 7 || i == n - 1) begin
                push(p, 1);
                p = 1'b1;
            end
        end
        if (ac) begin
            for (int b = 0; b < 2; b++) begin
                p = 1'b1;
                for (int k = 0; k < 8; k++) begin
                    push(cv[b*8+k], 2);
                    p = p ^ cv[b*8+k];
                end
                push(p, 3);
            end
        end
    endtask

    task automatic fill_random(input int n);
        for (int i = 0; i < 128; i++) src[i] = (i < n) ? 1'($urandom % 2) : 1'b0;
    endtask

    // rst_kind >= 0: hold the sink on the first bit of that kind, reset 2 cycles later
    task automatic run_frame(input int n, input logic ac, input int mode,
                             input int rst_kind, input int delay);
        logic [15:0] cv;
        int si, oi, cyc, hold;
        cv = ac ? crc_a(n / 8) : 16'h0000;
        build_exp(n, ac, cv);
        @(negedge clk);
        in_data_valid = 1'b1;
        in_data       = src[0];
        in_last       = (n == 1);
        out_req       = 1'b0;
        repeat (delay) begin
            @(negedge clk);
            #1 chk1("idle_valid", out_data_valid, 1'b0);
        end
        @(negedge clk);
        fdt_trigger = 1'b1;
        append_crc  = ac;
        crc         = cv;
        #1 chk1("pre_trigger_valid", out_data_valid, 1'b0);
        @(negedge clk);
        fdt_trigger = 1'b0;
        append_crc  = 1'b0;
        crc         = 16'h0000;
        #1 chk1("valid_rise", out_data_valid, 1'b1);
        si = 0; oi = 0; cyc = 0; hold = 0;
        while (oi < exp_len && cyc < 4000) begin
            in_data = src[(si < 128) ? si : 127];
            in_last = (si == n - 1);
            if (rst_kind >= 0 && exp_kind[oi] == rst_kind) begin
                out_req = 1'b0;
                hold++;
            end else begin
                out_req = (mode != 0) ? 1'($urandom % 2) : 1'b1;
            end
            #1;
            chk1("frame_valid", out_data_valid, 1'b1);
            chk1("out_data", out_data, exp_bit[oi]);
            chk1("out_last", out_last, oi == exp_len - 1);
            chk1("in_req", in_req, out_req && exp_kind[oi] == 0);
            if (out_req) begin
                got[oi] = out_data;
                if (exp_kind[oi] == 0) si++;
                oi++;
            end
            if (hold == 3) begin
                rst = 1'b1;
                break;
            end
            @(negedge clk);
            cyc++;
        end
        out_req = 1'b0;
        if (rst_kind >= 0) begin
            chki("rst_point_reached", hold, 3);
            @(negedge clk);
            rst = 1'b0;
            #1;
            chk1("rst_valid", out_data_valid, 1'b0);
            chk1("rst_last", out_last, 1'b0);
            chk1("rst_data", out_data, 1'b0);
            repeat (20) begin
                @(negedge clk);
                out_req = 1'($urandom % 2);
                #1;
                chk1("post_rst_valid", out_data_valid, 1'b0);
                chk1("post_rst_in_req", in_req, 1'b0);
            end
        end else begin
            chki("frame_complete", oi, exp_len);
            #1 chk1("end_valid", out_data_valid, 1'b0);
            repeat (6) begin
                @(negedge clk);
                out_req = 1'($urandom % 2);
                #1;
                chk1("no_second_frame", out_data_valid, 1'b0);
                chk1("no_stray_in_req", in_req, 1'b0);
            end
        end
        @(negedge clk);
        out_req       = 1'b0;
        in_data_valid = 1'b0;
        in_last       = 1'b0;
    endtask

    initial begin
        logic [7:0]  a5;
        logic [15:0] c;
        int          n;
        rst = 1'b1; fdt_trigger = 1'b0; append_crc = 1'b0; crc = 16'h0;
        in_data = 1'b0; in_data_valid = 1'b0; in_last = 1'b0; out_req = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk1("reset_valid", out_data_valid, 1'b0);
        chk1("reset_data", out_data, 1'b0);
        chk1("reset_last", out_last, 1'b0);
        chk1("reset_in_req", in_req, 1'b0);
        rst = 1'b0;

        // source pending but no trigger
        in_data_valid = 1'b1;
        repeat (256) begin
            @(negedge clk);
            in_data = 1'($urandom % 2);
            in_last = 1'($urandom % 2);
            out_req = 1'($urandom % 2);
            #1;
            chk1("notrig_valid", out_data_valid, 1'b0);
            chk1("notrig_in_req", in_req, 1'b0);
        end

        // trigger with nothing pending, then data without a fresh trigger
        in_data_valid = 1'b0;
        out_req = 1'b0;
        repeat (100) begin
            @(negedge clk); fdt_trigger = 1'b1;
            @(negedge clk); fdt_trigger = 1'b0;
            #1 chk1("dead_trigger_valid", out_data_valid, 1'b0);
        end
        in_data_valid = 1'b1;
        repeat (10) begin
            @(negedge clk);
            #1 chk1("late_valid_no_frame", out_data_valid, 1'b0);
        end
        in_data_valid = 1'b0;

        // single byte 0xA5, pinned literally
        a5 = 8'hA5;
        for (int i = 0; i < 128; i++) src[i] = (i < 8) ? a5[i] : 1'b0;
        run_frame(8, 1'b0, 0, -1, $urandom_range(100, 16));
        chki("model_a5_len", exp_len, 9);
        chk1("model_a5_parity", exp_bit[8], 1'b1);
        chki("a5_bits", int'({got[0], got[1], got[2], got[3], got[4],
                              got[5], got[6], got[7], got[8]}), int'(9'b101001011));

        // short and partial-byte frames
        for (int k = 1; k <= 8; k++) begin
            fill_random(k);
            run_frame(k, 1'b0, 1, -1, 2);
            chki("len_rule", exp_len, k + (k + 7) / 8);
        end
        repeat (5) begin
            n = $urandom_range(80, 9);
            fill_random(n);
            run_frame(n, 1'b0, 1, -1, 3);
        end

        // CRC_A reference: 00 00 -> A0 1E
        for (int i = 0; i < 128; i++) src[i] = 1'b0;
        c = crc_a(2);
        chki("crc_a_ref", int'(c), 32'h1EA0);
        repeat (4) begin
            n = 8 * $urandom_range(10, 1);
            fill_random(n);
            run_frame(n, 1'b1, 1, -1, 2);
            chki("crc_len_rule", exp_len, n + n / 8 + 18);
        end

        // mid-frame reset in each active region
        for (int kind = 0; kind < 4; kind++) begin
            fill_random(16);
            run_frame(16, 1'b1, 0, kind, 2);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/iso14443a_frame_encoder.md
Name: iso14443a_frame_encoder

Overview:
- PICC transmit-path framer for ISO/IEC 14443-3A. Sits between the bit-serial tx source (the tx_interface, bit mode) and the bit encoder/modulator.
- Waits for the frame-delay-time trigger, then streams the source's data bits. It inserts an odd parity bit after each byte and optionally appends a 16-bit CRC_A, also with parity.
- Output uses the same bit-serial tx handshake as the input.

Parameters:
- None.

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous active-high reset
- fdt_trigger  in  1  single-cycle pulse: frame delay time elapsed, transmission may start
- append_crc  in  1  append crc after the data; sampled on the start cycle
- crc  in  16  CRC_A of the frame's data; sampled on the start cycle
- in_data  in  1  current data bit from the source
- in_data_valid  in  1  source has a frame pending; held for the whole frame
- in_last  in  1  in_data is the last data bit of the frame
- in_req  out  1  pulse: current in_data consumed, source presents the next bit next cycle
- out_data  out  1  current output bit
- out_data_valid  out  1  output frame in progress
- out_last  out  1  out_data is the final bit of the frame
- out_req  in  1  pulse from sink: out_data consumed, present the next bit next cycle

Behaviour:
- Reset (synchronous, dominant): state=IDLE; out_data_valid=0, out_data=0, out_last=0, in_req=0; counters and parity cleared. A reset mid-frame returns to IDLE on the next edge. The rest of the frame is dropped, not resumed.
- States: IDLE, DATA, PARITY, CRC, CRC_PARITY, END.
- IDLE -> DATA when fdt_trigger=1 and in_data_valid=1 on the same edge.
  - out_data_valid rises on the cycle after fdt_trigger.
  - append_crc and crc are latched on this edge.
  - bit counter=0; parity accumulator=1 (odd).
- A trigger with in_data_valid=0 is ignored. A later in_data_valid does not start a frame without a new trigger.
- Handshake: the output bit holds until out_req; the next bit is valid the following cycle. out_req outside a frame is ignored.
- DATA: out_data=in_data; in_req=out_req (combinational pass-through, DATA state only). On out_req:
  - parity ^= bit; bit counter increments mod 8.
  - If counter reaches 8 or in_last=1 -> PARITY.
- PARITY: out_data=parity accumulator, so the byte plus its parity has an odd number of ones. A trailing partial byte (1-7 bits) also gets a parity bit over its sent bits. in_req=0. On out_req:
  - if more data remains -> DATA (counter and parity reset);
  - else if the latched append_crc=1 -> CRC;
  - else -> END.
- CRC: sends crc[7:0] then crc[15:8], LSB first. After each 8 bits -> CRC_PARITY (odd parity over that byte).
- CRC_PARITY: on out_req, after the first crc byte -> CRC; after the second -> END.
- out_last=1 while the final bit is presented: the final PARITY bit when no crc, or the second CRC_PARITY bit.
- END: out_data_valid=0, out_last=0; -> IDLE next cycle. At least 1 idle cycle separates frames.
- Frame length rules:
  - N data bits produce N + ceil(N/8) output bits;
  - with CRC, add 18 bits.
  - CRC is only meaningful when N is a multiple of 8; this is the caller's responsibility and is not checked.
- fdt_trigger while not IDLE is ignored.

Optional Feature:
- Macro FRAME_ENCODER_ASSERT_EN.
- When defined, the block compiles internal SVA:
  - out_data_valid rises 1 cycle after an accepted trigger;
  - state==IDLE the cycle after rst;
  - in_req never asserts outside DATA;
  - out_data/out_last stable while valid and no out_req.
- When undefined, there are no assertions and RTL behaviour is identical.

Decomposition:
- Package iso14443a_tx_pkg: State enum (3-bit, order IDLE, DATA, PARITY, CRC, CRC_PARITY, END), CRC_WIDTH=16, BITS_PER_BYTE=8.
- One natural sub-module, odd_parity_acc: clear, enable, bit in; parity out. Used for both data and crc bytes.

Test Plan:
- No trigger: queue 1-80 random bits, never pulse fdt_trigger -> out_data_valid stays 0 and in_req stays 0 for 256 cycles.
- Trigger with in_data_valid=0 (repeat 100) -> no output frame.
- 8 bits 0xA5, append_crc=0, trigger after 16-100 cycles:
  - out_data_valid rises exactly 1 cycle after the trigger;
  - output is 1,0,1,0,0,1,0,1 then parity 1; out_last on the 9th bit.
- N=1..8 and random 9..80 bits, no CRC -> N+ceil(N/8) bits, odd parity per (partial) byte, exactly one frame.
- append_crc=1, 1-10 random bytes, crc=CRC_A(data) -> data+parity followed by crc LSB byte, parity, MSB byte, parity; out_last on the last bit.
- Reset asserted 2 cycles after entering each of DATA, PARITY, CRC, CRC_PARITY -> state=IDLE and out_data_valid=0 next cycle; no further output.
